// File: rtl/full_adder_1bit_reg.sv
// full_adder_1bit_reg: registered 1-bit full adder with bit-serial chaining; FA_SERIAL_WORD_EN adds word assembly
module full_adder_1bit_reg #(
  parameter int WORD_BITS = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  input  logic                 A,
  input  logic                 B,
  input  logic                 Cin,
  input  logic                 chain_en,
  input  logic                 sow,
  output logic                 Sum,
  output logic                 Cout,
  output logic                 out_valid,
  output logic                 eow,
  output logic [WORD_BITS-1:0] word_sum,
  output logic                 word_cout
);
  localparam int CW = $clog2(WORD_BITS + 1);
  logic [CW-1:0] cnt, cnt_nx;
  logic c, s, co, last;
  // Cout doubles as the carry register: both load the same value under the same enable
  always_comb begin
    c      = (!chain_en || sow) ? Cin : Cout;
    s      = A ^ B ^ c;
    co     = (A & B) | (A & c) | (B & c);
    cnt_nx = sow ? CW'(1) : cnt + CW'(1);
    last   = chain_en && (cnt_nx == CW'(WORD_BITS));
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      Sum       <= 1'b0;
      Cout      <= 1'b0;
      out_valid <= 1'b0;
      eow       <= 1'b0;
      cnt       <= '0;
    end else begin
      out_valid <= in_valid;
      eow       <= in_valid && last;
      if (in_valid) begin
        Sum  <= s;
        Cout <= co;
        cnt  <= (!chain_en || last) ? '0 : cnt_nx;
      end
    end
  end
`ifdef FA_SERIAL_WORD_EN
  logic [WORD_BITS-1:0] sh, sh_base, sh_nx;
  always_comb begin
    sh_base = sow ? '0 : sh;
    sh_nx   = {s, sh_base[WORD_BITS-1:1]};
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sh        <= '0;
      word_sum  <= '0;
      word_cout <= 1'b0;
    end else if (in_valid && chain_en) begin
      sh <= sh_nx;
      if (last) begin
        word_sum  <= sh_nx;
        word_cout <= co;
      end else if (sow) begin
        word_sum <= '0;
      end
    end
  end
`else
  assign word_sum  = '0;
  assign word_cout = 1'b0;
`endif
endmodule

// File: tb/tb_full_adder_1bit_reg.sv
// tb_full_adder_1bit_reg: directed-vector bench for full_adder_1bit_reg
module tb_full_adder_1bit_reg;
  logic clk = 1'b0, rst_n = 1'b0;
  logic in_valid = 1'b0, A = 1'b0, B = 1'b0, Cin = 1'b0, chain_en = 1'b0, sow = 1'b0;
  logic Sum, Cout, out_valid, eow, word_cout;
  logic [3:0] word_sum;
  int n_cmp = 0, n_bad = 0;

  full_adder_1bit_reg #(.WORD_BITS(4)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .A(A), .B(B), .Cin(Cin),
    .chain_en(chain_en), .sow(sow), .Sum(Sum), .Cout(Cout), .out_valid(out_valid),
    .eow(eow), .word_sum(word_sum), .word_cout(word_cout)
  );

  always #5 clk = ~clk;

  task automatic step(input logic v, a, b, ci, ce, so);
    in_valid = v; A = a; B = b; Cin = ci; chain_en = ce; sow = so;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    repeat (2) @(posedge clk);
    #1;
    n_cmp++;
    if ({Sum, Cout, out_valid, eow, word_sum, word_cout} !== 9'b0) begin
      n_bad++;
      $display("FAIL reset: got %b %b %b %b %b %b, want all 0", Sum, Cout, out_valid, eow, word_sum, word_cout);
    end
    #3 rst_n = 1'b1;
  endtask

  task automatic test_truth_table;
    logic [7:0] es, ec;
    es = 8'b10010110;
    ec = 8'b11101000;
    for (int i = 0; i < 8; i++) begin
      step(1'b1, i[2], i[1], i[0], 1'b0, 1'b0);
      n_cmp++;
      if ({Sum, Cout, out_valid, eow} !== {es[i], ec[i], 1'b1, 1'b0}) begin
        n_bad++;
        $display("FAIL truth_%0d: sum/cout/valid/eow=%b%b%b%b want %b%b10", i, Sum, Cout, out_valid, eow, es[i], ec[i]);
      end
    end
  endtask

  task automatic test_hold;
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    n_cmp++;
    if ({Sum, Cout, out_valid, eow} !== 4'b1100) begin
      n_bad++;
      $display("FAIL hold: sum/cout/valid/eow=%b%b%b%b want 1100", Sum, Cout, out_valid, eow);
    end
  endtask

  // Adds a+b LSB-first over 4 beats with sow on beat 1; checks every beat and the assembled word
  task automatic run_word(input string nm, input logic [3:0] a, b, es, ec, ews, input logic ewc);
    for (int i = 0; i < 4; i++) begin
      step(1'b1, a[i], b[i], 1'b0, 1'b1, i == 0);
      n_cmp++;
      if ({Sum, Cout, out_valid, eow} !== {es[i], ec[i], 1'b1, i == 3}) begin
        n_bad++;
        $display("FAIL %s_beat%0d: sum/cout/valid/eow=%b%b%b%b want %b%b1%b", nm, i, Sum, Cout, out_valid, eow, es[i], ec[i], i == 3);
      end
    end
    n_cmp++;
`ifdef FA_SERIAL_WORD_EN
    if ({word_sum, word_cout} !== {ews, ewc}) begin
      n_bad++;
      $display("FAIL %s_word: word_sum=%b word_cout=%b want %b %b", nm, word_sum, word_cout, ews, ewc);
    end
`else
    if ({word_sum, word_cout} !== 5'b0) begin
      n_bad++;
      $display("FAIL %s_word: word_sum=%b word_cout=%b want 0000 0 (feature off)", nm, word_sum, word_cout);
    end
`endif
  endtask

  task automatic test_serial;
    run_word("serial", 4'b0111, 4'b0011, 4'b1010, 4'b0111, 4'b1010, 1'b0);
  endtask

  task automatic test_overflow;
    run_word("overflow", 4'b1111, 4'b0001, 4'b0000, 4'b1111, 4'b0000, 1'b1);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    n_cmp++;
    if ({eow, Cout} !== 2'b01) begin
      n_bad++;
      $display("FAIL overflow_once: eow=%b cout=%b want 0 1", eow, Cout);
    end
  endtask

  // No sow after eow: carry 1 from the overflow word chains into the next word
  task automatic test_back_to_back;
    logic [3:0] es;
    es = 4'b0001;
    for (int i = 0; i < 4; i++) begin
      step(1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
      n_cmp++;
      if ({Sum, Cout, eow} !== {es[i], 1'b0, i == 3}) begin
        n_bad++;
        $display("FAIL chain_beat%0d: sum/cout/eow=%b%b%b want %b0%b", i, Sum, Cout, eow, es[i], i == 3);
      end
    end
`ifdef FA_SERIAL_WORD_EN
    n_cmp++;
    if ({word_sum, word_cout} !== 5'b00010) begin
      n_bad++;
      $display("FAIL chain_word: word_sum=%b word_cout=%b want 0001 0", word_sum, word_cout);
    end
`endif
  endtask

  task automatic test_mid_sow;
    logic [5:0] ee;
    ee = 6'b100000;
    for (int i = 0; i < 6; i++) begin
      step(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, i == 0 || i == 2);
      n_cmp++;
      if (eow !== ee[i]) begin
        n_bad++;
        $display("FAIL midsow_beat%0d: eow=%b want %b", i, eow, ee[i]);
      end
    end
  endtask

  task automatic test_async_reset;
    step(1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1);
    step(1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({Sum, Cout, out_valid, eow, word_sum, word_cout} !== 9'b0) begin
      n_bad++;
      $display("FAIL async_reset: got %b %b %b %b %b %b, want all 0", Sum, Cout, out_valid, eow, word_sum, word_cout);
    end
    @(posedge clk);
    #1;
    n_cmp++;
    if ({Sum, Cout, out_valid, eow} !== 4'b0) begin
      n_bad++;
      $display("FAIL reset_held: sum/cout/valid/eow=%b%b%b%b want 0000", Sum, Cout, out_valid, eow);
    end
    #2 rst_n = 1'b1;
    @(posedge clk);
    #1;
    test_serial();
  endtask

  initial begin
    test_reset();
    test_truth_table();
    test_hold();
    test_serial();
    test_overflow();
    test_back_to_back();
    test_mid_sow();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
